// File: rtl/psx_ddr_pkg.sv
// Shared types for the PSX DDR command queue: bridge size codes, the queued
// request record and the issue sequencer states.
package psx_ddr_pkg;

  localparam logic [1:0] CMD_8BYTE   = 2'd0;
  localparam logic [1:0] CMD_32BYTE  = 2'd1;
  localparam logic [1:0] CMD_4BYTE   = 2'd2;
  localparam logic [1:0] CMD_ILLEGAL = 2'd3;

  // Tags are stored at this width; the top zero-extends its TAG_W-bit tag.
  localparam int TAG_MAX_W = 16;

  // Everything the bridge sees for one command.
  typedef struct packed {
    logic         write;
    logic [1:0]   size;
    logic [14:0]  adr;
    logic [2:0]   sub_adr;
    logic [15:0]  mask;
    logic [255:0] data;
  } bridge_cmd_t;

  typedef struct packed {
    bridge_cmd_t          cmd;
    logic [TAG_MAX_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } q_state_e;

endpackage

// File: rtl/psx_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit so that full and
// empty are distinguishable when the indices match.
module psx_req_fifo
  import psx_ddr_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  req_t        din,
  input  logic        pop,
  output req_t        dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  req_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage has no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/psx_ddr_cmd_queue.sv
// GPU-to-DDR-bridge command queue: buffers requests in order, issues them one
// at a time on the bridge's command/busy protocol and returns tagged read data.
module psx_ddr_cmd_queue
  import psx_ddr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_nRst,
  input  logic             i_reqValid,
  output logic             o_reqReady,
  input  logic             i_reqWrite,
  input  logic [1:0]       i_reqSize,
  input  logic [14:0]      i_reqAdr,
  input  logic [2:0]       i_reqSubAdr,
  input  logic [15:0]      i_reqMask,
  input  logic [255:0]     i_reqData,
  input  logic [TAG_W-1:0] i_reqTag,
  output logic             o_rspValid,
  output logic [255:0]     o_rspData,
  output logic [TAG_W-1:0] o_rspTag,
  output logic             o_errSticky,
  output logic [CW-1:0]    o_pending,
  output logic             o_command,
  output logic             o_writeElseRead,
  output logic [1:0]       o_commandSize,
  output logic [14:0]      o_targetAddr,
  output logic [2:0]       o_subAddr,
  output logic [15:0]      o_writeMask,
  output logic [255:0]     o_dataClient,
  input  logic             i_busyClient,
  input  logic             i_dataValidClient,
  input  logic [255:0]     i_dataClient
);

  q_state_e    state, state_nxt;
  req_t        req_in, head;
  bridge_cmd_t issued, bridge;
  logic        fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic        accept, illegal, push, can_issue;
  logic        issue, proto_err, rsp_fire;
  logic        inflight_write;
  logic [TAG_W-1:0] inflight_tag;

  // Ready is held low while reset is asserted so every output reads 0 then.
  assign o_reqReady = i_nRst & ~fifo_full;
  assign accept     = i_reqValid & o_reqReady;
  assign illegal    = accept & (i_reqSize == CMD_ILLEGAL);
  assign push       = accept & ~illegal;
  assign can_issue  = ~i_busyClient & ~fifo_empty;

  assign req_in = '{cmd: '{write: i_reqWrite, size: i_reqSize, adr: i_reqAdr,
                           sub_adr: i_reqSubAdr, mask: i_reqMask, data: i_reqData},
                    tag: TAG_MAX_W'(i_reqTag)};

  psx_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_nRst),
    .push  (push),
    .din   (req_in),
    .pop   (issue),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    proto_err = 1'b0;
    rsp_fire  = 1'b0;
    unique case (state)
      IDLE: begin
        if (can_issue) begin
          issue     = 1'b1;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (i_busyClient) begin
          state_nxt = WAIT_DONE;
        end else begin
          proto_err = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        // Completion passes through IDLE combinationally so the next command can go out now.
        if (inflight_write ? ~i_busyClient : i_dataValidClient) begin
          rsp_fire = ~inflight_write;
          if (can_issue) begin
            issue     = 1'b1;
            state_nxt = WAIT_BUSY;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      issued         <= '0;
      inflight_write <= 1'b0;
      inflight_tag   <= '0;
      o_errSticky    <= 1'b0;
      o_rspValid     <= 1'b0;
      o_rspData      <= '0;
      o_rspTag       <= '0;
    end else begin
      o_rspValid <= rsp_fire;
      if (issue) begin
        issued         <= head.cmd;
        inflight_write <= head.cmd.write;
        inflight_tag   <= TAG_W'(head.tag);
      end
      if (rsp_fire) begin
        o_rspData <= i_dataClient;
        o_rspTag  <= inflight_tag;
      end
      if (illegal | proto_err) o_errSticky <= 1'b1;
    end
  end

  // Bridge fields follow the head in the issue cycle and hold until the next issue.
  assign bridge          = issue ? head.cmd : issued;
  assign o_command       = issue;
  assign o_writeElseRead = bridge.write;
  assign o_commandSize   = bridge.size;
  assign o_targetAddr    = bridge.adr;
  assign o_subAddr       = bridge.sub_adr;
  assign o_writeMask     = bridge.mask;
  assign o_dataClient    = bridge.data;
  assign o_pending       = fifo_count + CW'(state != IDLE);

endmodule

// File: tb/tb_psx_ddr_cmd_queue.sv
// Self-checking bench: a timeline model of the DDR bridge plus an in-order
// expectation queue of issued commands and returned reads.
module tb_psx_ddr_cmd_queue;
  import psx_ddr_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             i_reqValid, i_reqWrite;
  logic [1:0]       i_reqSize;
  logic [14:0]      i_reqAdr;
  logic [2:0]       i_reqSubAdr;
  logic [15:0]      i_reqMask;
  logic [255:0]     i_reqData;
  logic [TAG_W-1:0] i_reqTag;
  logic             i_busyClient, i_dataValidClient;
  logic [255:0]     i_dataClient;
  logic             o_reqReady, o_rspValid, o_errSticky, o_command, o_writeElseRead;
  logic [255:0]     o_rspData, o_dataClient;
  logic [TAG_W-1:0] o_rspTag;
  logic [CW-1:0]    o_pending;
  logic [1:0]       o_commandSize;
  logic [14:0]      o_targetAddr;
  logic [2:0]       o_subAddr;
  logic [15:0]      o_writeMask;

  psx_ddr_cmd_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_nRst(rst_n),
    .i_reqValid(i_reqValid), .o_reqReady(o_reqReady), .i_reqWrite(i_reqWrite),
    .i_reqSize(i_reqSize), .i_reqAdr(i_reqAdr), .i_reqSubAdr(i_reqSubAdr),
    .i_reqMask(i_reqMask), .i_reqData(i_reqData), .i_reqTag(i_reqTag),
    .o_rspValid(o_rspValid), .o_rspData(o_rspData), .o_rspTag(o_rspTag),
    .o_errSticky(o_errSticky), .o_pending(o_pending),
    .o_command(o_command), .o_writeElseRead(o_writeElseRead), .o_commandSize(o_commandSize),
    .o_targetAddr(o_targetAddr), .o_subAddr(o_subAddr), .o_writeMask(o_writeMask),
    .o_dataClient(o_dataClient), .i_busyClient(i_busyClient),
    .i_dataValidClient(i_dataValidClient), .i_dataClient(i_dataClient)
  );

  int tests_run = 0, tests_failed = 0;

  // Reference state: queued requests, bridge timeline, expected response.
  req_t         exp_q[$];
  bit           br_active, br_write, br_mute, inflight, rsp_due, exp_err, noise, use_fixed_data;
  int           br_t, br_len, fixed_len;
  logic [255:0] br_data, fixed_data, rsp_exp_data;
  logic [TAG_W-1:0] br_tag, rsp_exp_tag;
  bridge_cmd_t  last_cmd, last_cmd_obs;
  int           cyc, last_acc_cyc, last_cmd_cyc, cmd_count, rsp_count, b2b_hits;
  bit           last_acc, last_ready;
  logic [255:0] last_rsp_data;
  logic [TAG_W-1:0] last_rsp_tag;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    br_active = 0; br_mute = 0; inflight = 0; rsp_due = 0; exp_err = 0; last_cmd = '0;
  endtask

  // One clock cycle, entered and left at a falling edge with client inputs already driven.
  task automatic cycle();
    bit busy, dv, done, acc, allowed;
    bridge_cmd_t obs;
    req_t e, r;
    int exp_pend;
    done = br_active && !br_mute && (br_t == br_len + 1);
    busy = br_active && !br_mute && (br_t <= br_len);
    dv   = done && !br_write;
    i_busyClient      = busy;
    i_dataValidClient = dv || (noise && (!br_active || br_write) && ($urandom_range(0, 3) == 0));
    i_dataClient      = dv ? br_data : rand256();
    #1;
    exp_pend = exp_q.size() + (inflight ? 1 : 0);
    tests_run++;
    if (o_pending !== CW'(exp_pend)) begin
      tests_failed++; $display("FAIL pending: got %0d want %0d (cycle %0d)", o_pending, exp_pend, cyc);
    end
    tests_run++;
    if (o_errSticky !== exp_err) begin
      tests_failed++; $display("FAIL err_sticky: got %b want %b (cycle %0d)", o_errSticky, exp_err, cyc);
    end
    tests_run++;
    if (o_rspValid !== rsp_due) begin
      tests_failed++; $display("FAIL rsp_valid: got %b want %b (cycle %0d)", o_rspValid, rsp_due, cyc);
    end else if (rsp_due) begin
      tests_run++;
      if ({o_rspTag, o_rspData} !== {rsp_exp_tag, rsp_exp_data}) begin
        tests_failed++;
        $display("FAIL rsp_data: got tag %h data %h want tag %h data %h", o_rspTag, o_rspData, rsp_exp_tag, rsp_exp_data);
      end
      rsp_count++; last_rsp_data = o_rspData; last_rsp_tag = o_rspTag;
    end
    rsp_due = dv; rsp_exp_data = br_data; rsp_exp_tag = br_tag;

    obs = {o_writeElseRead, o_commandSize, o_targetAddr, o_subAddr, o_writeMask, o_dataClient};
    acc = (i_reqValid === 1'b1) && (o_reqReady === 1'b1);
    last_acc = acc; last_ready = (o_reqReady === 1'b1);
    allowed = !br_active || done;
    if (br_active) begin
      if (br_mute) begin br_active = 0; inflight = 0; exp_err = 1; end
      else if (done) begin br_active = 0; inflight = 0; end
      else br_t++;
    end
    if (o_command === 1'b1) begin
      tests_run++;
      if (!allowed) begin
        tests_failed++; $display("FAIL cmd_outstanding: command while bridge busy (cycle %0d)", cyc);
      end
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++; $display("FAIL cmd_unexpected: got %h want no command", obs);
        br_write = obs.write; br_tag = '0; last_cmd = obs;
      end else begin
        e = exp_q.pop_front();
        if (obs !== e.cmd) begin
          tests_failed++; $display("FAIL cmd_fields: got %h want %h", obs, e.cmd);
        end
        br_write = e.cmd.write; br_tag = e.tag[TAG_W-1:0]; last_cmd = e.cmd;
      end
      if (dv) b2b_hits++;
      br_active = 1; br_t = 1; inflight = 1;
      br_len  = (fixed_len > 0) ? fixed_len : $urandom_range(1, 5);
      br_data = use_fixed_data ? fixed_data : rand256();
      cmd_count++; last_cmd_cyc = cyc; last_cmd_obs = obs;
    end else begin
      tests_run++;
      if (obs !== last_cmd) begin
        tests_failed++; $display("FAIL cmd_hold: got %h want %h (cycle %0d)", obs, last_cmd, cyc);
      end
    end
    if (acc) begin
      last_acc_cyc = cyc;
      if (i_reqSize == 2'd3) exp_err = 1;
      else begin
        r.cmd = {i_reqWrite, i_reqSize, i_reqAdr, i_reqSubAdr, i_reqMask, i_reqData};
        r.tag = TAG_MAX_W'(i_reqTag);
        exp_q.push_back(r);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input bit wr, input logic [1:0] sz, input logic [14:0] adr, input logic [2:0] sub,
                      input logic [15:0] mask, input logic [255:0] data, input logic [TAG_W-1:0] tag);
    bit ok = 0;
    i_reqValid = 1; i_reqWrite = wr; i_reqSize = sz; i_reqAdr = adr;
    i_reqSubAdr = sub; i_reqMask = mask; i_reqData = data; i_reqTag = tag;
    for (int k = 0; k < 100 && !ok; k++) begin cycle(); ok = last_acc; end
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL send_timeout: got no accept want accept within 100 cycles"); end
    i_reqValid = 0;
  endtask

  task automatic drain(input int budget);
    bit idle = 0;
    i_reqValid = 0;
    for (int k = 0; k < budget && !idle; k++) begin
      cycle();
      idle = (exp_q.size() == 0) && !br_active && !inflight && !rsp_due;
    end
    tests_run++;
    if (!idle) begin tests_failed++; $display("FAIL drain_timeout: got %0d queued want 0", exp_q.size()); end
  endtask

  task automatic check_all_zero(input string name);
    tests_run++;
    if ({o_reqReady, o_rspValid, o_errSticky, o_pending, o_command, o_writeElseRead, o_commandSize,
         o_targetAddr, o_subAddr, o_writeMask, o_dataClient, o_rspData, o_rspTag} !== '0) begin
      tests_failed++;
      $display("FAIL %s: got ready=%b rsp=%b err=%b pend=%0d cmd=%b adr=%h want all zero",
               name, o_reqReady, o_rspValid, o_errSticky, o_pending, o_command, o_targetAddr);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; i_reqValid = 0; i_reqWrite = 0; i_reqSize = 0; i_reqAdr = 0; i_reqSubAdr = 0;
    i_reqMask = 0; i_reqData = 0; i_reqTag = 0; i_busyClient = 0; i_dataValidClient = 0; i_dataClient = 0;
    model_clear(); noise = 0; fixed_len = 0; use_fixed_data = 0;
    @(negedge clk); #1;
    check_all_zero("reset_outputs");
    @(negedge clk); rst_n = 1; #1;
    tests_run++;
    if (o_reqReady !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", o_reqReady); end
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int n0 = rsp_count;
    fixed_len = 6; use_fixed_data = 1; fixed_data = {32{8'hA5}};
    send(0, CMD_32BYTE, 15'h0123, 3'd0, 16'h0, 256'h0, 4'd5);
    drain(50);
    tests_run++;
    if (last_cmd_cyc - last_acc_cyc != 1) begin
      tests_failed++; $display("FAIL read_latency: got %0d want 1", last_cmd_cyc - last_acc_cyc);
    end
    tests_run++;
    if (rsp_count != n0 + 1 || last_rsp_data !== {32{8'hA5}} || last_rsp_tag !== 4'd5) begin
      tests_failed++;
      $display("FAIL read_rsp: got n=%0d tag %h data %h want n=1 tag 5 data a5..a5", rsp_count - n0, last_rsp_tag, last_rsp_data);
    end
    use_fixed_data = 0;
  endtask

  task automatic test_fill();
    int c0 = cmd_count;
    fixed_len = 6;
    for (int i = 0; i < 5; i++) send(1, CMD_32BYTE, 15'(16 + i), 3'd0, 16'hFFFF, rand256(), 4'd0);
    cycle();
    tests_run++;
    if (last_ready) begin tests_failed++; $display("FAIL fill_ready: got 1 want 0 with 4 buffered"); end
    drain(100);
    tests_run++;
    if (cmd_count - c0 != 5) begin tests_failed++; $display("FAIL fill_count: got %0d want 5", cmd_count - c0); end
  endtask

  task automatic test_back_to_back();
    int b0 = b2b_hits;
    fixed_len = 3;
    send(1, CMD_8BYTE, 15'h0040, 3'd2, 16'h00FF, rand256(), 4'd0);
    send(0, CMD_8BYTE, 15'h0040, 3'd2, 16'h0000, rand256(), 4'd9);
    send(1, CMD_8BYTE, 15'h0040, 3'd2, 16'hFF00, rand256(), 4'd0);
    drain(60);
    tests_run++;
    if (b2b_hits - b0 != 1) begin
      tests_failed++; $display("FAIL b2b_issue: got %0d want 1 command on read data-valid", b2b_hits - b0);
    end
  endtask

  task automatic test_small_write();
    fixed_len = 2;
    send(1, CMD_4BYTE, 15'h0777, 3'b001, 16'h0003, rand256(), 4'd0);
    cycle();
    tests_run++;
    if (last_cmd_obs.size !== 2'd2 || last_cmd_obs.sub_adr !== 3'd1 || last_cmd_obs.mask !== 16'h0003) begin
      tests_failed++;
      $display("FAIL small_write: got size %0d sub %0d mask %h want 2 1 0003",
               last_cmd_obs.size, last_cmd_obs.sub_adr, last_cmd_obs.mask);
    end
    drain(40);
  endtask

  task automatic test_random();
    int r0 = rsp_count, reads = 0;
    bit wr;
    fixed_len = 0; noise = 1;
    for (int i = 0; i < 60; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) cycle();
      wr = 1'($urandom_range(0, 1));
      if (!wr) reads++;
      send(wr, 2'($urandom_range(0, 2)), 15'($urandom()), 3'($urandom()), 16'($urandom()), rand256(), 4'($urandom()));
    end
    drain(400);
    noise = 0;
    tests_run++;
    if (rsp_count - r0 != reads) begin
      tests_failed++; $display("FAIL random_rsp_count: got %0d want %0d", rsp_count - r0, reads);
    end
  endtask

  task automatic test_illegal();
    int c0 = cmd_count;
    send(0, 2'd3, 15'h0100, 3'd0, 16'h0, rand256(), 4'd1);
    for (int i = 0; i < 4; i++) cycle();
    tests_run++;
    if (o_errSticky !== 1'b1 || cmd_count != c0) begin
      tests_failed++; $display("FAIL illegal_size: got err %b cmds %0d want err 1 cmds 0", o_errSticky, cmd_count - c0);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    fixed_len = 6;
    send(0, CMD_32BYTE, 15'h0200, 3'd0, 16'h0, rand256(), 4'd3);
    send(1, CMD_32BYTE, 15'h0201, 3'd0, 16'hFFFF, rand256(), 4'd0);
    cycle(); cycle();
    rst_n = 0; #1;
    check_all_zero("reset_mid_outputs");
    model_clear();
    i_busyClient = 0; i_dataValidClient = 0;
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 10; i++) cycle();
    c0 = cmd_count;
    send(1, CMD_8BYTE, 15'h0300, 3'd0, 16'h000F, rand256(), 4'd0);
    drain(40);
    tests_run++;
    if (cmd_count - c0 != 1) begin tests_failed++; $display("FAIL reset_recover: got %0d cmds want 1", cmd_count - c0); end
  endtask

  task automatic test_protocol_error();
    br_mute = 1;
    send(1, CMD_8BYTE, 15'h0400, 3'd0, 16'h0001, rand256(), 4'd0);
    for (int i = 0; i < 3; i++) cycle();
    tests_run++;
    if (o_errSticky !== 1'b1) begin tests_failed++; $display("FAIL protocol_error: got err %b want 1", o_errSticky); end
    br_mute = 0;
    drain(20);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; cmd_count = 0; rsp_count = 0; b2b_hits = 0;
    test_reset();
    test_single_read();
    test_fill();
    test_back_to_back();
    test_small_write();
    test_random();
    test_illegal();
    test_reset_mid();
    test_protocol_error();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
